// File: rtl/serial_alu_pkg.sv
// -----------------------------------------------------------------------------
// serial_alu_pkg
// Shared definitions for the bit-serial ALU: opcode values, the opcode field
// width and the FSM state type used by serial_alu_n.
// -----------------------------------------------------------------------------
package serial_alu_pkg;

  localparam int OPC_BITS = 3;

  localparam logic [OPC_BITS-1:0] OP_ADD  = 3'b000;
  localparam logic [OPC_BITS-1:0] OP_SUB  = 3'b001;
  localparam logic [OPC_BITS-1:0] OP_AND  = 3'b010;
  localparam logic [OPC_BITS-1:0] OP_OR   = 3'b011;
  localparam logic [OPC_BITS-1:0] OP_XOR  = 3'b100;
  localparam logic [OPC_BITS-1:0] OP_SHL  = 3'b101;
  localparam logic [OPC_BITS-1:0] OP_SHR  = 3'b110;
  localparam logic [OPC_BITS-1:0] OP_SLTU = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_OPC      = 4'd1,
    ST_OPA      = 4'd2,
    ST_OPB      = 4'd3,
    ST_EXEC     = 4'd4,
    ST_TX_START = 4'd5,
    ST_TX_DATA  = 4'd6,
    ST_TX_C     = 4'd7,
    ST_TX_Z     = 4'd8
  } state_t;

endpackage

// File: rtl/serial_alu_core.sv
// -----------------------------------------------------------------------------
// serial_alu_core
// Purely combinational WIDTH-bit ALU. All arithmetic is unsigned and modulo
// 2^WIDTH.
//   op     : 3-bit opcode (see serial_alu_pkg)
//   a, b   : operands
//   result : operation result
//   c      : carry / borrow / shifted-out bit / SLTU result, depending on op
//   z      : 1 when result is all zeros
// -----------------------------------------------------------------------------
module serial_alu_core
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPC_BITS-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    result,
  output logic                c,
  output logic                z
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           a_lt_b;

  // One extra bit captures the carry-out of the add and the borrow of the
  // subtract.
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign a_lt_b = diff[WIDTH];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD:  begin result = sum[WIDTH-1:0];  c = sum[WIDTH];  end
      OP_SUB:  begin result = diff[WIDTH-1:0]; c = a_lt_b;      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  begin result = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
      OP_SHR:  begin result = {1'b0, a[WIDTH-1:1]}; c = a[0];       end
      OP_SLTU: begin result = {{(WIDTH-1){1'b0}}, a_lt_b}; c = a_lt_b; end
      default: begin result = '0; c = 1'b0; end
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/serial_alu_n.sv
// -----------------------------------------------------------------------------
// serial_alu_n
// Bit-serial ALU. Receives {start, opcode[2:0], A, B} on Data_in, one bit per
// clock, computes the result and returns {start, result, C, Z} on Data_out.
// Operand and result bits travel in MSB_FIRST order; the opcode is always MSB
// first. Both lines idle at 0.
//   Clock    : system clock, rising edge
//   Reset    : asynchronous, active-high; aborts any frame in progress
//   Data_in  : serial input frame
//   Data_out : serial output frame (registered)
//   Busy     : high from start-bit acceptance until the Z bit has been sent
//              (registered)
// -----------------------------------------------------------------------------
module serial_alu_n
  import serial_alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Data_in,
  output logic Data_out,
  output logic Busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q,   cnt_d;
  logic [OPC_BITS-1:0] op_q,    op_d;
  logic [WIDTH-1:0]    a_q,     a_d;
  logic [WIDTH-1:0]    b_q,     b_d;
  logic [WIDTH-1:0]    res_q,   res_d;
  logic                c_q,     c_d;
  logic                z_q,     z_d;
  logic                dout_q,  dout_d;
  logic                busy_q,  busy_d;

  logic [WIDTH-1:0]    core_res;
  logic                core_c;
  logic                core_z;
  logic                cnt_zero;
  logic                tx_bit;
  logic [WIDTH-1:0]    res_shifted;

  serial_alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (core_res),
    .c      (core_c),
    .z      (core_z)
  );

  // Operand shift-in: the first bit received lands in the bit position the
  // chosen order assigns to it once the whole field has arrived.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                input logic             bit_in);
    if (MSB_FIRST) return {r[WIDTH-2:0], bit_in};
    else           return {bit_in, r[WIDTH-1:1]};
  endfunction

  assign cnt_zero    = (cnt_q == '0);
  assign tx_bit      = MSB_FIRST ? res_q[WIDTH-1] : res_q[0];
  assign res_shifted = MSB_FIRST ? {res_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    z_d     = z_q;
    dout_d  = 1'b0;
    busy_d  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        // Busy follows the start bit directly, so it drops at the first IDLE
        // edge after the Z bit and rises again at the next accepted start.
        busy_d = Data_in;
        if (Data_in) begin
          state_d = ST_OPC;
          cnt_d   = CW'(OPC_BITS - 1);
        end
      end

      ST_OPC: begin
        op_d = {op_q[OPC_BITS-2:0], Data_in};
        if (cnt_zero) begin
          state_d = ST_OPA;
          cnt_d   = CW'(WIDTH - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_OPA: begin
        a_d = shift_in(a_q, Data_in);
        if (cnt_zero) begin
          state_d = ST_OPB;
          cnt_d   = CW'(WIDTH - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_OPB: begin
        b_d = shift_in(b_q, Data_in);
        if (cnt_zero) state_d = ST_EXEC;
        else          cnt_d   = cnt_q - 1'b1;
      end

      ST_EXEC: begin
        res_d   = core_res;
        c_d     = core_c;
        z_d     = core_z;
        state_d = ST_TX_START;
      end

      ST_TX_START: begin
        dout_d  = 1'b1;
        cnt_d   = CW'(WIDTH - 1);
        state_d = ST_TX_DATA;
      end

      ST_TX_DATA: begin
        dout_d = tx_bit;
        res_d  = res_shifted;
        if (cnt_zero) state_d = ST_TX_C;
        else          cnt_d   = cnt_q - 1'b1;
      end

      ST_TX_C: begin
        dout_d  = c_q;
        state_d = ST_TX_Z;
      end

      ST_TX_Z: begin
        dout_d  = z_q;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the operand/result registers are ordinary flops, not memories, so
  // they are cleared by the asynchronous reset along with the control state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the values
      // from before the edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign Data_out = dout_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_serial_alu_n.sv
// -----------------------------------------------------------------------------
// tb_serial_alu_n
// Drives two instances of serial_alu_n (WIDTH=8 LSB first, WIDTH=16 MSB first)
// with directed and random frames and compares the returned frames against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_alu_n;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        z;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic din8  = 1'b0;
  logic din16 = 1'b0;
  logic dout8, busy8, dout16, busy16;

  int tests = 0;
  int fails = 0;

  serial_alu_n #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
    .Clock    (clk),
    .Reset    (rst),
    .Data_in  (din8),
    .Data_out (dout8),
    .Busy     (busy8)
  );

  serial_alu_n #(.WIDTH(16), .MSB_FIRST(1'b1)) u_dut16 (
    .Clock    (clk),
    .Reset    (rst),
    .Data_in  (din16),
    .Data_out (dout16),
    .Busy     (busy16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain unsigned arithmetic modulo 2^w.
  function automatic exp_t model(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t    e;
    longint  m  = longint'(1) << w;
    longint  sa = longint'(a);
    longint  sb = longint'(b);
    longint  s;
    e.c = 1'b0;
    case (op)
      3'd0: begin s = sa + sb;  e.r = 32'(s % m); e.c = (s >= m); end
      3'd1: begin e.r = 32'((sa - sb + m) % m); e.c = (sa < sb); end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: begin s = sa * 2;   e.r = 32'(s % m); e.c = (s >= m); end
      3'd6: begin e.r = 32'(sa / 2); e.c = (sa % 2 == 1); end
      default: begin e.r = (sa < sb) ? 32'd1 : 32'd0; e.c = (sa < sb); end
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  task automatic set_din(input int sel, input logic v);
    if (sel != 0) din16 = v;
    else          din8  = v;
  endtask

  function automatic logic get_dout(input int sel);
    return (sel != 0) ? dout16 : dout8;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy16 : busy8;
  endfunction

  // Called at a falling edge; holds Reset for 10 time units.
  task automatic pulse_reset(input string tag);
    din8  = 1'b0;
    din16 = 1'b0;
    rst   = 1'b1;
    #1;
    check({tag, ".rst_dout8"},  dout8,  1'b0);
    check({tag, ".rst_busy8"},  busy8,  1'b0);
    check({tag, ".rst_dout16"}, dout16, 1'b0);
    check({tag, ".rst_busy16"}, busy16, 1'b0);
    #9;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check({tag, ".post_rst_dout8"}, dout8, 1'b0);
      check({tag, ".post_rst_busy8"}, busy8, 1'b0);
    end
  endtask

  // Sends one frame and checks the complete response timeline. The first
  // frame bit is driven immediately, so calls issued back-to-back present a
  // start bit one edge after Busy falls. abort_in / abort_tx select a bit
  // index after which a reset pulse aborts the frame.
  task automatic run_op(input int sel, input logic [2:0] op,
                        input logic [31:0] a_in, input logic [31:0] b_in,
                        input logic hold, input string tag,
                        input int abort_in = -1, input int abort_tx = -1);
    int          w;
    logic [31:0] mask, a, b, rx;
    logic        bits[$];
    exp_t        e;
    w    = (sel != 0) ? 16 : 8;
    mask = (32'h1 << w) - 32'h1;
    a    = a_in & mask;
    b    = b_in & mask;
    e    = model(w, op, a, b);

    bits.push_back(1'b1);
    for (int i = 2; i >= 0; i--) bits.push_back(op[i]);
    for (int i = 0; i < w; i++) bits.push_back(a[(sel != 0) ? (w - 1 - i) : i]);
    for (int i = 0; i < w; i++) bits.push_back(b[(sel != 0) ? (w - 1 - i) : i]);

    for (int i = 0; i < bits.size(); i++) begin
      set_din(sel, bits[i]);
      @(negedge clk);
      if (i == 0) check({tag, ".busy_rise"}, get_busy(sel), 1'b1);
      if (i == abort_in) begin
        pulse_reset(tag);
        return;
      end
    end

    // Last B bit was sampled at edge k; now between k and k+1.
    set_din(sel, hold);
    @(negedge clk);
    check({tag, ".exec_dout"}, get_dout(sel), 1'b0);
    check({tag, ".exec_busy"}, get_busy(sel), 1'b1);
    @(negedge clk);
    check({tag, ".start"}, get_dout(sel), 1'b1);

    rx = '0;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      check({tag, ".tx_busy"}, get_busy(sel), 1'b1);
      if (sel != 0) rx[w - 1 - i] = get_dout(sel);
      else          rx[i]         = get_dout(sel);
      if (i == abort_tx) begin
        pulse_reset(tag);
        return;
      end
    end
    check({tag, ".data"}, rx, e.r);

    @(negedge clk);
    check({tag, ".carry"}, get_dout(sel), e.c);
    @(negedge clk);
    check({tag, ".zero"}, get_dout(sel), e.z);
    check({tag, ".z_busy"}, get_busy(sel), 1'b1);
    set_din(sel, 1'b0);
    @(negedge clk);
    check({tag, ".end_dout"}, get_dout(sel), 1'b0);
    check({tag, ".end_busy"}, get_busy(sel), 1'b0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset.dout8",  dout8,  1'b0);
    check("reset.busy8",  busy8,  1'b0);
    check("reset.dout16", dout16, 1'b0);
    check("reset.busy16", busy16, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=8, LSB first.
    run_op(0, 3'd0, 32'h3C, 32'h05, 1'b0, "add_3c_05");
    run_op(0, 3'd1, 32'h05, 32'h05, 1'b0, "sub_eq");
    run_op(0, 3'd1, 32'h03, 32'h05, 1'b0, "sub_borrow");
    run_op(0, 3'd0, 32'hFF, 32'h01, 1'b0, "add_wrap");
    run_op(0, 3'd5, 32'h81, 32'h00, 1'b0, "shl_81");
    run_op(0, 3'd7, 32'h10, 32'h20, 1'b0, "sltu_lt");
    run_op(0, 3'd6, 32'h01, 32'h00, 1'b0, "shr_01");

    // Directed WIDTH=16, MSB first.
    run_op(1, 3'd4, 32'hA5A5, 32'hFFFF, 1'b0, "xor16");
    run_op(1, 3'd0, 32'hFFFF, 32'h0001, 1'b0, "add16_wrap");

    // Reset in the middle of the B field, then a clean frame.
    run_op(0, 3'd0, 32'h12, 32'h34, 1'b0, "rst_opb", 4 + 8 + 3);
    run_op(0, 3'd0, 32'h01, 32'h01, 1'b0, "after_rst_opb");

    // Reset in the middle of the result bits, then a clean frame.
    run_op(0, 3'd0, 32'h55, 32'h22, 1'b0, "rst_tx", -1, 3);
    run_op(0, 3'd0, 32'h01, 32'h01, 1'b0, "after_rst_tx");

    // Data_in held high through EXEC/TX must not start a frame.
    run_op(0, 3'd3, 32'h0F, 32'hF0, 1'b1, "hold_hi");
    repeat (3) begin
      @(negedge clk);
      check("hold_hi.idle_busy", busy8, 1'b0);
      check("hold_hi.idle_dout", dout8, 1'b0);
    end

    // Back-to-back frames: second start bit one edge after Busy falls.
    run_op(0, 3'd2, 32'hCC, 32'hAA, 1'b1, "b2b_first");
    run_op(0, 3'd1, 32'h40, 32'h41, 1'b0, "b2b_second");
    run_op(1, 3'd7, 32'h8000, 32'h7FFF, 1'b1, "b2b16_first");
    run_op(1, 3'd1, 32'h1234, 32'h1234, 1'b0, "b2b16_second");

    // Random frames on both instances.
    for (int n = 0; n < 24; n++)
      run_op(0, 3'($urandom_range(0, 7)), $urandom, $urandom,
             1'($urandom_range(0, 1)), "rnd8");
    for (int n = 0; n < 16; n++)
      run_op(1, 3'($urandom_range(0, 7)), $urandom, $urandom,
             1'($urandom_range(0, 1)), "rnd16");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_alu_n.md
Name: serial_alu_n

Overview:
- Parametrised bit-serial ALU. It receives an opcode and two WIDTH-bit operands as one serial frame on Data_in, computes the result, and returns result plus flags as a serial frame on Data_out.
- Successor to the fixed-width serial ALU: adds a width parameter, selectable bit order, eight operations, carry/zero flags and a Busy indication.
- Sits between a single-wire serial link and the rest of the datapath test environment.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- MSB_FIRST, 0, operand and result bit order on both wires: 0 = LSB first, 1 = MSB first. The opcode is always sent MSB first.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Data_in  input  1  serial input frame; sampled on the rising edge.
- Data_out  output  1  serial output frame; registered.
- Busy  output  1  high from start-bit acceptance until the last output bit has been sent; registered.

Behaviour:
- Clocking and reset: one clock, Clock. Reset is asynchronous and active-high.
  - While Reset is high: state = IDLE, Data_out = 0, Busy = 0, bit counter = 0, operand/result registers = 0.
  - Reset mid-frame (input or output) aborts the frame immediately. Nothing further is emitted; the block restarts in IDLE.
- Input frame: start bit (1), then 3 opcode bits, then A (WIDTH bits), then B (WIDTH bits). Total 4 + 2*WIDTH bits, one bit per clock.
- Line idle level is 0, in both directions.
- States:
  - IDLE: Data_in = 1 at an edge -> OPC, Busy goes to 1. Data_in = 0 stays in IDLE.
  - OPC: 3 edges -> OPA.
  - OPA: WIDTH edges -> OPB.
  - OPB: WIDTH edges -> EXEC.
  - EXEC: 1 cycle; result and flags are registered -> TX_START.
  - TX_START: Data_out = 1 -> TX_DATA.
  - TX_DATA: WIDTH cycles of result bits in MSB_FIRST order -> TX_C.
  - TX_C: Data_out = carry -> TX_Z.
  - TX_Z: Data_out = zero -> IDLE. Data_out returns to 0 and Busy to 0 at the edge leaving TX_Z.
- Latency: the last B bit is sampled at edge k. Data_out = 1 (start bit) is visible from edge k+2 to edge k+3.
- Data_in is ignored in EXEC and all TX states. A 1 seen while Busy is never treated as a start bit.
- A new start bit is accepted at the first edge at which the block is in IDLE. Back-to-back frames are therefore legal once Busy has been low for one edge.
- Operations (opcode value: result, C; all arithmetic unsigned, modulo 2^WIDTH):
  - 000 ADD: A+B; C = carry-out.
  - 001 SUB: A-B; C = borrow (A<B).
  - 010 AND; C = 0.
  - 011 OR; C = 0.
  - 100 XOR; C = 0.
  - 101 SHL: A<<1; C = A[WIDTH-1].
  - 110 SHR: A>>1 logical; C = A[0].
  - 111 SLTU: result = 1 if A<B, else 0; C = result[0].
- Z = 1 iff result == 0, for every opcode.
- The bit counter is sized clog2(WIDTH)+1 and counts down, reloading at each state boundary. It never wraps inside a field.

Decomposition:
- Package serial_alu_pkg holds:
  - opcode constants: OP_ADD … OP_SLTU, 3-bit;
  - state encoding constants;
  - OPC_BITS = 3.
- Sub-module serial_alu_core: purely combinational, parameter WIDTH; inputs op, a, b; outputs result, c, z. It is instantiated once, and its outputs are registered in EXEC.
- Shift-in/shift-out registers, counter and FSM stay in serial_alu_n.

Test Plan:
- WIDTH=8, LSB first: ADD A=0x3C, B=0x05 -> output frame start, 0x41, C=0, Z=0; Busy low one edge after the Z bit.
- SUB A=0x05, B=0x05 -> 0x00, C=0, Z=1. SUB A=0x03, B=0x05 -> 0xFE, C=1, Z=0.
- ADD 0xFF + 0x01 -> 0x00, C=1, Z=1. SHL A=0x81 -> 0x02, C=1. SLTU A=0x10, B=0x20 -> 0x01, C=1, Z=0.
- Set MSB_FIRST=1, WIDTH=16: XOR A=0xA5A5, B=0xFFFF -> 0x5A5A sent MSB first. Check start bit at edge k+2, then 16 data bits, C=0, Z=0.
- Reset pulse of 10 ns during the OPB field, then during TX_DATA -> Data_out=0 and Busy=0 immediately. A fresh ADD 0x01+0x01 afterwards returns 0x02.
- Data_in held 1 throughout EXEC and TX -> no spurious frame. A start bit presented one edge after Busy falls is accepted, and the second result is correct.
